iob_div_arbiter: RTL and testbench

- Shares one external iob_div_subshift divider among N_REQ requesters using round-robin arbitration and per-requester valid/ready request and response handshakes.
- Captures operands, sequences the divider's en/done protocol, latches the results, and returns them to the granted requester.
- Resolves divide-by-zero locally without starting the divider.
- Sits between the arithmetic clients, such as the float/posit units, and the divider core.

---
 rtl/iob_div_arbiter.sv | 167 ++++++++++++++++
 tb/tb_iob_div_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : iob_div_arbiter
// Description : Round-robin front end that shares one iob_div_subshift divider
//               among N_REQ requesters with valid/ready request and response.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_div_arbiter #(
    parameter int DATA_W = 32,
    parameter int N_REQ  = 4
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0]          req_sign,
    input  logic [N_REQ*DATA_W-1:0]   req_dividend,
    input  logic [N_REQ*DATA_W-1:0]   req_divisor,

    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]         rsp_quotient,
    output logic [DATA_W-1:0]         rsp_remainder,
    output logic                      rsp_dbz,

    output logic                      busy,

    output logic                      div_en,
    output logic                      div_sign,
    output logic [DATA_W-1:0]         div_dividend,
    output logic [DATA_W-1:0]         div_divisor,
    input  logic                      div_done,
    input  logic [DATA_W-1:0]         div_quotient,
    input  logic [DATA_W-1:0]         div_remainder
);

    localparam int c_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_RUN      = 2'd1;
    localparam logic [1:0] c_ZERO_RSP = 2'd2;
    localparam logic [1:0] c_RESP     = 2'd3;

    logic [1:0]          r_state;
    logic [c_PTR_W-1:0]  r_ptr;
    logic [c_PTR_W-1:0]  r_owner;
    logic                r_sign;
    logic [DATA_W-1:0]   r_dividend;
    logic [DATA_W-1:0]   r_divisor;
    logic [DATA_W-1:0]   r_quot;
    logic [DATA_W-1:0]   r_rem;
    logic                r_dbz;

    logic                w_grant_found;
    logic [c_PTR_W-1:0]  w_grant;
    logic                w_accept;
    logic                w_rsp_ack;
    logic                w_sel_sign;
    logic [DATA_W-1:0]   w_sel_dividend;
    logic [DATA_W-1:0]   w_sel_divisor;

    // Index of the requester 'offset' places after 'base', wrapping at N_REQ.
    function automatic logic [c_PTR_W-1:0] f_rr_idx(input logic [c_PTR_W-1:0] base,
                                                     input int offset);
        int v_sum;
        v_sum = int'(base) + offset;
        if (v_sum >= N_REQ) begin
            v_sum = v_sum - N_REQ;
        end
        return c_PTR_W'(v_sum);
    endfunction

    always_comb begin
        w_grant_found = 1'b0;
        w_grant       = r_ptr;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_grant_found && req_valid[f_rr_idx(r_ptr, k)]) begin
                w_grant_found = 1'b1;
                w_grant       = f_rr_idx(r_ptr, k);
            end
        end
    end

    assign w_accept       = (r_state == c_IDLE) && w_grant_found;
    assign w_sel_sign     = req_sign[w_grant];
    assign w_sel_dividend = req_dividend[int'(w_grant)*DATA_W +: DATA_W];
    assign w_sel_divisor  = req_divisor[int'(w_grant)*DATA_W +: DATA_W];
    assign w_rsp_ack      = (r_state == c_RESP) && rsp_ready[r_owner];

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (r_state == c_RESP) begin
            rsp_valid[r_owner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_ptr      <= c_PTR_W'(N_REQ - 1);
            r_owner    <= '0;
            r_sign     <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_dbz      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_sign     <= w_sel_sign;
                        r_dividend <= w_sel_dividend;
                        r_divisor  <= w_sel_divisor;
                        r_owner    <= w_grant;
                        r_ptr      <= w_grant;
                        r_state    <= (w_sel_divisor == '0) ? c_ZERO_RSP : c_RUN;
                    end
                end
                c_RUN: begin
                    if (div_done) begin
                        r_quot  <= div_quotient;
                        r_rem   <= div_remainder;
                        r_dbz   <= 1'b0;
                        r_state <= c_RESP;
                    end
                end
                c_ZERO_RSP: begin
                    // Divide-by-zero is answered locally; the divider stays idle.
                    r_quot  <= '1;
                    r_rem   <= r_dividend;
                    r_dbz   <= 1'b1;
                    r_state <= c_RESP;
                end
                c_RESP: begin
                    if (w_rsp_ack) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // div_en falls as soon as RUN is left, which also clears the divider between jobs.
    assign div_en        = (r_state == c_RUN);
    assign div_sign      = r_sign;
    assign div_dividend  = r_dividend;
    assign div_divisor   = r_divisor;

    assign rsp_quotient  = r_quot;
    assign rsp_remainder = r_rem;
    assign rsp_dbz       = (r_state == c_RESP) && r_dbz;
    assign busy          = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_iob_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_div_arbiter
// Description : Self-checking bench for iob_div_arbiter with a divider model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_div_arbiter;

    localparam int DATA_W = 32;
    localparam int N_REQ  = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_sign;
    logic [N_REQ*DATA_W-1:0] req_dividend;
    logic [N_REQ*DATA_W-1:0] req_divisor;
    logic [N_REQ-1:0]        rsp_valid;
    logic [N_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]       rsp_quotient;
    logic [DATA_W-1:0]       rsp_remainder;
    logic                    rsp_dbz;
    logic                    busy;
    logic                    div_en;
    logic                    div_sign;
    logic [DATA_W-1:0]       div_dividend;
    logic [DATA_W-1:0]       div_divisor;
    logic                    div_done;
    logic [DATA_W-1:0]       div_quotient;
    logic [DATA_W-1:0]       div_remainder;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int en_cycles = 0;

    typedef struct {
        int          owner;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    iob_div_arbiter #(.DATA_W(DATA_W), .N_REQ(N_REQ)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_sign      (req_sign),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_dbz       (rsp_dbz),
        .busy          (busy),
        .div_en        (div_en),
        .div_sign      (div_sign),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'd0};
            return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
        end
        return {a / b, a % b};
    endfunction

    // Divider model: done rises DATA_W+4 cycles after en, cleared when en drops.
    int unsigned m_cnt = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_q = '0;
    logic [31:0] m_r = '0;

    always @(posedge clk) begin
        if (!div_en) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
        end else if (!m_done) begin
            if (m_cnt == DATA_W + 3) begin
                m_done     <= 1'b1;
                {m_q, m_r} <= ref_div(div_sign, div_dividend, div_divisor);
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    assign div_done      = m_done;
    assign div_quotient  = m_q;
    assign div_remainder = m_r;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (div_en) en_cycles <= en_cycles + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic s, input logic [31:0] dvd, input logic [31:0] dvs);
        req_valid[idx]                       = 1'b1;
        req_sign[idx]                        = s;
        req_dividend[idx*DATA_W +: DATA_W]   = dvd;
        req_divisor[idx*DATA_W +: DATA_W]    = dvs;
    endtask

    task automatic push(input int owner, input logic [31:0] q, input logic [31:0] r,
                        input logic dbz, input int lat);
        exp_t e;
        e.owner = owner; e.q = q; e.r = r; e.dbz = dbz; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic wait_accept(output int g, output int at);
        logic found;
        found = 1'b0;
        g = -1;
        at = -1;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) begin
                found = 1'b1;
                at = cyc;
                chk("req_ready_onehot", 64'($countones(req_ready)), 64'd1);
                chk("div_en_low_at_accept", {63'd0, div_en}, 64'd0);
                for (int k = 0; k < N_REQ; k++) if (req_ready[k]) g = k;
            end
        end
        chk("accept_seen", {63'd0, found}, 64'd1);
    endtask

    task automatic wait_rsp(input int acc_cyc);
        exp_t e;
        logic found;
        found = 1'b0;
        e = sb.pop_front();
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (rsp_valid != '0) found = 1'b1;
        end
        chk("rsp_seen", {63'd0, found}, 64'd1);
        chk("rsp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
        chk("rsp_valid_owner", {60'd0, rsp_valid}, 64'(1 << e.owner));
        chk("rsp_quotient", {32'd0, rsp_quotient}, {32'd0, e.q});
        chk("rsp_remainder", {32'd0, rsp_remainder}, {32'd0, e.r});
        chk("rsp_dbz", {63'd0, rsp_dbz}, {63'd0, e.dbz});
        chk("div_en_low_at_rsp", {63'd0, div_en}, 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_div_en"}, {63'd0, div_en}, 64'd0);
        chk({tag, "_req_ready"}, {60'd0, req_ready}, 64'd0);
        chk({tag, "_rsp_valid"}, {60'd0, rsp_valid}, 64'd0);
        chk({tag, "_rsp_dbz"}, {63'd0, rsp_dbz}, 64'd0);
        chk({tag, "_rsp_quotient"}, {32'd0, rsp_quotient}, 64'd0);
        chk({tag, "_rsp_remainder"}, {32'd0, rsp_remainder}, 64'd0);
        chk({tag, "_div_dividend"}, {32'd0, div_dividend}, 64'd0);
    endtask

    initial begin
        int g;
        int a;
        int a2;
        int h;
        int en0;
        logic [63:0] qr;

        rst = 1'b1;
        req_valid = '0;
        req_sign = '0;
        req_dividend = '0;
        req_divisor = '0;
        rsp_ready = '1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");

        // All four requesters valid from reset: grant order 0,1,2,3,0.
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b0, 32'(1000 + i * 37), 32'(i + 3));
        for (int n = 0; n < 5; n++) begin
            int gi;
            gi = n % N_REQ;
            qr = ref_div(1'b0, 32'(1000 + gi * 37), 32'(gi + 3));
            push(gi, qr[63:32], qr[31:0], 1'b0, DATA_W + 6);
        end
        for (int n = 0; n < 5; n++) begin
            wait_accept(g, a);
            chk("grant_order", 64'(g), 64'(n % N_REQ));
            if (n == 4) begin
                @(posedge clk);
                #1 req_valid = '0;
            end
            wait_rsp(a);
        end

        // Unsigned 100/7 from requester 2.
        @(posedge clk);
        #1 set_req(2, 1'b0, 32'd100, 32'd7);
        push(2, 32'd14, 32'd2, 1'b0, DATA_W + 6);
        wait_accept(g, a);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(a);

        // Signed -100/7 from requester 1.
        @(posedge clk);
        #1 set_req(1, 1'b1, 32'hFFFF_FF9C, 32'd7);
        push(1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, DATA_W + 6);
        wait_accept(g, a);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(a);

        // Signed overflow MIN/-1 passes through unchanged.
        @(posedge clk);
        #1 set_req(2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        push(2, 32'h8000_0000, 32'd0, 1'b0, DATA_W + 6);
        wait_accept(g, a);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(a);

        // Divide by zero from requester 3: no divider activity.
        @(posedge clk);
        en0 = en_cycles;
        #1 set_req(3, 1'b0, 32'h0000_1234, 32'd0);
        push(3, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 2);
        wait_accept(g, a);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(a);
        chk("dbz_div_en_never", 64'(en_cycles - en0), 64'd0);

        // Response back-pressure on requester 0 while requester 1 waits.
        @(posedge clk);
        #1 rsp_ready = 4'b1110;
        set_req(0, 1'b0, 32'd50, 32'd5);
        push(0, 32'd10, 32'd0, 1'b0, DATA_W + 6);
        wait_accept(g, a);
        chk("bp_grant0", 64'(g), 64'd0);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        set_req(1, 1'b0, 32'd81, 32'd9);
        push(1, 32'd9, 32'd0, 1'b0, DATA_W + 6);
        wait_rsp(a);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", {60'd0, rsp_valid}, 64'd1);
            chk("bp_quotient", {32'd0, rsp_quotient}, 64'd10);
            chk("bp_remainder", {32'd0, rsp_remainder}, 64'd0);
            chk("bp_div_en", {63'd0, div_en}, 64'd0);
            chk("bp_req_ready", {60'd0, req_ready}, 64'd0);
        end
        @(posedge clk);
        #1 rsp_ready = '1;
        @(negedge clk);
        h = cyc;
        chk("bp_ack_cycle_valid", {60'd0, rsp_valid}, 64'd1);
        wait_accept(g, a2);
        chk("bp_next_grant", 64'(g), 64'd1);
        chk("bp_next_accept_cycle", 64'(a2), 64'(h + 1));
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(a2);

        // Reset pulse in the middle of a division.
        @(posedge clk);
        #1 set_req(0, 1'b1, 32'hFFFF_FF00, 32'd16);
        wait_accept(g, a);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("midrun_busy", {63'd0, busy}, 64'd1);
        chk("midrun_div_en", {63'd0, div_en}, 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all_zero("midrun_reset");
        @(posedge clk);
        #1 set_req(0, 1'b1, 32'hFFFF_FF00, 32'd16);
        push(0, 32'hFFFF_FFF0, 32'd0, 1'b0, DATA_W + 6);
        wait_accept(g, a);
        chk("post_reset_grant", 64'(g), 64'd0);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(a);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
